// File: rtl/gol_board_engine_if.sv
// rtl/gol_board_engine_if.sv - control/edit inputs and board outputs of the life board engine
interface gol_board_engine_if #(
   parameter int ROWS  = 8,
   parameter int COLS  = 16,
   parameter int IDX_W = 7
);
   logic [1:0]           game_state;
   logic [IDX_W-1:0]     cell_idx;
   logic                 btn0;
   logic                 btn1;
   logic [ROWS*COLS-1:0] board;
   logic                 busy;
   logic                 gen_done;
   logic [15:0]          gen_count;

   modport master (
      output game_state, cell_idx, btn0, btn1,
      input  board, busy, gen_done, gen_count
   );

   modport slave (
      input  game_state, cell_idx, btn0, btn1,
      output board, busy, gen_done, gen_count
   );
endinterface

// File: rtl/gol_board_engine.sv
// rtl/gol_board_engine.sv - Conway B3/S23 board engine, one cell per clock into a shadow buffer with atomic commit; GOL_WRAP_EN selects a toroidal board
module gol_board_engine #(
   parameter int ROWS    = 8,
   parameter int COLS    = 16,
   parameter int IDX_W   = 7,
   parameter int GEN_DIV = 1024
) (
   input  logic              i_clka,
   input  logic              i_rst,
   gol_board_engine_if.slave bus
);
   localparam int N      = ROWS * COLS;
   localparam int TICK_W = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;
   localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

   localparam logic [1:0] GS_IDLE    = 2'b00;
   localparam logic [1:0] GS_PROGRAM = 2'b01;
   localparam logic [1:0] GS_RUN     = 2'b10;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'b00,
      ST_CALC   = 2'b01,
      ST_COMMIT = 2'b10
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [TICK_W-1:0] r_tick,  w_tick_nxt;
   logic [IDX_W-1:0]  r_idx,   w_idx_nxt;
   logic [ROW_W-1:0]  r_row,   w_row_nxt;
   logic [COL_W-1:0]  r_col,   w_col_nxt;
   logic              w_commit;
   logic              w_calc_we;

   logic [N-1:0]      r_board;
   logic [N-1:0]      r_shadow;
   logic [15:0]       r_gen_count;
   logic              r_gen_done;

   logic [3:0]        w_ncount;
   logic              w_next_cell;
   logic              w_in_range;
   int                w_rr;
   int                w_cc;
   logic [IDX_W-1:0]  w_nidx;
   logic              w_nb;

   // an edit cursor past the last cell must not touch the board
   assign w_in_range = ({1'b0, bus.cell_idx} < (IDX_W+1)'(N));

   // count the eight neighbours of the cell under scan; row/col counters track idx so no divider is needed
   always_comb begin
      w_ncount = '0;
      w_rr     = 0;
      w_cc     = 0;
      w_nidx   = '0;
      w_nb     = 1'b0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            w_rr   = int'(r_row) + dr;
            w_cc   = int'(r_col) + dc;
            w_nb   = 1'b0;
            w_nidx = '0;
`ifdef GOL_WRAP_EN
            if (w_rr < 0) w_rr = ROWS - 1;
            else if (w_rr >= ROWS) w_rr = 0;
            if (w_cc < 0) w_cc = COLS - 1;
            else if (w_cc >= COLS) w_cc = 0;
            w_nidx = IDX_W'(w_rr * COLS + w_cc);
            w_nb   = r_board[w_nidx];
`else
            if (w_rr >= 0 && w_rr < ROWS && w_cc >= 0 && w_cc < COLS) begin
               w_nidx = IDX_W'(w_rr * COLS + w_cc);
               w_nb   = r_board[w_nidx];
            end
`endif
            if (!(dr == 0 && dc == 0)) begin
               w_ncount = w_ncount + {3'b000, w_nb};
            end
         end
      end
   end

   // B3/S23: born on exactly 3, survive on 2 or 3
   assign w_next_cell = (w_ncount == 4'd3) || (r_board[r_idx] && (w_ncount == 4'd2));

   // engine next state: IDLE/PROGRAM park the engine, RUN advances, PAUSE only finishes an open scan
   always_comb begin
      w_state_nxt = r_state;
      w_tick_nxt  = r_tick;
      w_idx_nxt   = r_idx;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_commit    = 1'b0;
      w_calc_we   = 1'b0;
      if (bus.game_state == GS_IDLE || bus.game_state == GS_PROGRAM) begin
         w_state_nxt = ST_WAIT;
         w_tick_nxt  = '0;
         w_idx_nxt   = '0;
         w_row_nxt   = '0;
         w_col_nxt   = '0;
      end else begin
         case (r_state)
            ST_WAIT: begin
               if (bus.game_state == GS_RUN) begin
                  if (r_tick == TICK_W'(GEN_DIV - 1)) begin
                     w_state_nxt = ST_CALC;
                     w_tick_nxt  = '0;
                     w_idx_nxt   = '0;
                     w_row_nxt   = '0;
                     w_col_nxt   = '0;
                  end else begin
                     w_tick_nxt = r_tick + 1'b1;
                  end
               end
            end
            ST_CALC: begin
               w_calc_we = 1'b1;
               w_idx_nxt = r_idx + 1'b1;
               if (r_col == COL_W'(COLS - 1)) begin
                  w_col_nxt = '0;
                  w_row_nxt = r_row + 1'b1;
               end else begin
                  w_col_nxt = r_col + 1'b1;
               end
               if (r_idx == IDX_W'(N - 1)) begin
                  w_state_nxt = ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               w_commit    = 1'b1;
               w_state_nxt = ST_WAIT;
               w_tick_nxt  = '0;
               w_idx_nxt   = '0;
               w_row_nxt   = '0;
               w_col_nxt   = '0;
            end
            default: begin
               w_state_nxt = ST_WAIT;
            end
         endcase
      end
   end

   // engine state and scan counters
   always_ff @(posedge i_clka or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_WAIT;
         r_tick  <= '0;
         r_idx   <= '0;
         r_row   <= '0;
         r_col   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tick  <= w_tick_nxt;
         r_idx   <= w_idx_nxt;
         r_row   <= w_row_nxt;
         r_col   <= w_col_nxt;
      end
   end

   // board, shadow and generation bookkeeping; board only changes by edit, clear or commit
   always_ff @(posedge i_clka or posedge i_rst) begin
      if (i_rst) begin
         r_board     <= '0;
         r_shadow    <= '0;
         r_gen_count <= '0;
         r_gen_done  <= 1'b0;
      end else begin
         r_gen_done <= w_commit;
         if (w_calc_we) begin
            r_shadow[r_idx] <= w_next_cell;
         end
         case (bus.game_state)
            GS_IDLE: begin
               r_board     <= '0;
               r_gen_count <= '0;
            end
            GS_PROGRAM: begin
               if (w_in_range && (bus.btn0 ^ bus.btn1)) begin
                  r_board[bus.cell_idx] <= bus.btn1;
               end
            end
            default: begin
               if (w_commit) begin
                  r_board     <= r_shadow;
                  r_gen_count <= r_gen_count + 16'd1;
               end
            end
         endcase
      end
   end

   assign bus.board     = r_board;
   assign bus.busy      = (r_state != ST_WAIT);
   assign bus.gen_done  = r_gen_done;
   assign bus.gen_count = r_gen_count;
endmodule

// File: tb/tb_gol_board_engine.sv
// tb/tb_gol_board_engine.sv - gol_board_engine against a whole-board life model plus directed literal checks
module tb_gol_board_engine;
   localparam int ROWS    = 8;
   localparam int COLS    = 16;
   localparam int IDX_W   = 7;
   localparam int GEN_DIV = 4;
   localparam int N       = ROWS * COLS;
   localparam int PER     = GEN_DIV + N + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   gol_board_engine_if #(.ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W)) bus ();
   gol_board_engine #(.ROWS(ROWS), .COLS(COLS), .IDX_W(IDX_W), .GEN_DIV(GEN_DIV)) u_dut (
      .i_clka(clk),
      .i_rst (rst),
      .bus   (bus)
   );

   gol_board_engine_if #(.ROWS(8), .COLS(15), .IDX_W(7)) bus15 ();
   gol_board_engine #(.ROWS(8), .COLS(15), .IDX_W(7), .GEN_DIV(GEN_DIV)) u_dut15 (
      .i_clka(clk),
      .i_rst (rst),
      .bus   (bus15)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // whole-board generation step straight from the rule
   function automatic logic [N-1:0] life_step(input logic [N-1:0] b);
      logic [N-1:0] nb;
      int live, rr, cc;
      nb = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            live = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0) begin
                     rr = r + dr;
                     cc = c + dc;
`ifdef GOL_WRAP_EN
                     rr = (rr + ROWS) % ROWS;
                     cc = (cc + COLS) % COLS;
                     live += int'(b[rr*COLS+cc]);
`else
                     if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                        live += int'(b[rr*COLS+cc]);
`endif
                  end
               end
            end
            nb[r*COLS+c] = (live == 3) || (b[r*COLS+c] && live == 2);
         end
      end
      return nb;
   endfunction

   function automatic logic [N-1:0] cells(input int a, input int b, input int c);
      logic [N-1:0] v;
      v = '0;
      if (a >= 0) v[a] = 1'b1;
      if (b >= 0) v[b] = 1'b1;
      if (c >= 0) v[c] = 1'b1;
      return v;
   endfunction

   // reference model: phase counts edges into the current generation (WAIT, then N scan edges, then commit)
   logic [N-1:0] m_board;
   logic [15:0]  m_count;
   logic         m_done;
   int           m_phase;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_board <= '0;
         m_count <= '0;
         m_done  <= 1'b0;
         m_phase <= 0;
      end else begin
         m_done <= 1'b0;
         case (bus.game_state)
            2'b00: begin
               m_board <= '0;
               m_count <= '0;
               m_phase <= 0;
            end
            2'b01: begin
               m_phase <= 0;
               if (int'(bus.cell_idx) < N && bus.btn1 && !bus.btn0) m_board[bus.cell_idx] <= 1'b1;
               else if (int'(bus.cell_idx) < N && bus.btn0 && !bus.btn1) m_board[bus.cell_idx] <= 1'b0;
            end
            default: begin
               if (bus.game_state == 2'b10 || m_phase >= GEN_DIV) begin
                  if (m_phase == GEN_DIV + N) begin
                     m_board <= life_step(m_board);
                     m_count <= m_count + 16'd1;
                     m_done  <= 1'b1;
                     m_phase <= 0;
                  end else begin
                     m_phase <= m_phase + 1;
                  end
               end
            end
         endcase
      end
   end

   // cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst) begin
         check("cyc_board", 128'(bus.board), 128'(m_board));
         check("cyc_busy", 128'(bus.busy), 128'(m_phase >= GEN_DIV));
         check("cyc_gen_done", 128'(bus.gen_done), 128'(m_done));
         check("cyc_gen_count", 128'(bus.gen_count), 128'(m_count));
      end
   end

   task automatic press(input int idx, input logic b0, input logic b1);
      bus.cell_idx = IDX_W'(idx);
      bus.btn0 = b0;
      bus.btn1 = b1;
      @(negedge clk);
      bus.btn0 = 1'b0;
      bus.btn1 = 1'b0;
   endtask

   task automatic press15(input int idx, input logic b0, input logic b1);
      bus15.cell_idx = 7'(idx);
      bus15.btn0 = b0;
      bus15.btn1 = b1;
      @(negedge clk);
      bus15.btn0 = 1'b0;
      bus15.btn1 = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit, output int k);
      k = 0;
      while (k < limit) begin
         @(negedge clk);
         k++;
         if (bus.gen_done === 1'b1) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s: no gen_done within %0d cycles, required one", name, limit);
      k = -1;
   endtask

   task automatic wait_busy(input string name, input int limit);
      int k;
      k = 0;
      while (k < limit) begin
         @(negedge clk);
         k++;
         if (bus.busy === 1'b1) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s: busy never rose within %0d cycles", name, limit);
   endtask

   initial begin
      int k;
      int cnt;
      int sel;
      bus.game_state = 2'b00;
      bus.cell_idx   = '0;
      bus.btn0       = 1'b0;
      bus.btn1       = 1'b0;
      bus15.game_state = 2'b00;
      bus15.cell_idx   = '0;
      bus15.btn0       = 1'b0;
      bus15.btn1       = 1'b0;

      // reset values
      @(negedge clk);
      check("rst_board", 128'(bus.board), 128'(0));
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_gen_done", 128'(bus.gen_done), 128'(0));
      check("rst_gen_count", 128'(bus.gen_count), 128'(0));
      rst = 1'b0;
      @(negedge clk);

      check("model_blinker", 128'(life_step(cells(52, 53, 54))), 128'(cells(37, 53, 69)));

      // blinker
      bus.game_state = 2'b01;
      press(52, 1'b0, 1'b1);
      press(53, 1'b0, 1'b1);
      press(54, 1'b0, 1'b1);
      check("prog_board", 128'(bus.board), 128'(cells(52, 53, 54)));
      bus.game_state = 2'b10;
      wait_done("blink1", 2 * PER, k);
      check("blink1_latency", 128'(k), 128'(PER));
      check("blink1_board", 128'(bus.board), 128'(cells(37, 53, 69)));
      check("blink1_count", 128'(bus.gen_count), 128'(1));
      wait_done("blink2", 2 * PER, k);
      check("blink2_latency", 128'(k), 128'(PER));
      check("blink2_board", 128'(bus.board), 128'(cells(52, 53, 54)));
      check("blink2_count", 128'(bus.gen_count), 128'(2));

      // button in RUN is ignored
      press(10, 1'b0, 1'b1);
      check("run_btn_ignored", 128'(bus.board), 128'(cells(52, 53, 54)));

      // IDLE while scanning
      wait_busy("idle_busy", 2 * PER);
      bus.game_state = 2'b00;
      @(negedge clk);
      check("idle_board", 128'(bus.board), 128'(0));
      check("idle_count", 128'(bus.gen_count), 128'(0));
      check("idle_busy", 128'(bus.busy), 128'(0));
      check("idle_gen_done", 128'(bus.gen_done), 128'(0));

      // vertical blinker on column 0
      bus.game_state = 2'b01;
      press(16, 1'b0, 1'b1);
      press(32, 1'b0, 1'b1);
      press(48, 1'b0, 1'b1);
      bus.game_state = 2'b10;
      wait_done("border", 2 * PER, k);
      check("border_latency", 128'(k), 128'(PER));
`ifdef GOL_WRAP_EN
      check("border_board", 128'(bus.board), 128'(cells(47, 32, 33)));
`else
      check("border_board", 128'(bus.board), 128'(cells(32, 33, -1)));
`endif

      // both buttons together leave the cell alone
      bus.game_state = 2'b01;
      press(5, 1'b0, 1'b1);
      press(5, 1'b1, 1'b1);
      check("both_btn_keep1", 128'(bus.board[5]), 128'(1));
      press(5, 1'b1, 1'b0);
      press(5, 1'b1, 1'b1);
      check("both_btn_keep0", 128'(bus.board[5]), 128'(0));

      // PAUSE mid-scan finishes exactly one generation then holds
      bus.game_state = 2'b00;
      @(negedge clk);
      bus.game_state = 2'b01;
      press(52, 1'b0, 1'b1);
      press(53, 1'b0, 1'b1);
      press(54, 1'b0, 1'b1);
      bus.game_state = 2'b10;
      wait_busy("pause_busy", 2 * PER);
      bus.game_state = 2'b11;
      wait_done("pause_commit", N + 4, k);
      check("pause_board", 128'(bus.board), 128'(cells(37, 53, 69)));
      check("pause_count", 128'(bus.gen_count), 128'(1));
      cnt = 0;
      for (int i = 0; i < 10 * GEN_DIV; i++) begin
         @(negedge clk);
         if (bus.gen_done === 1'b1) cnt++;
      end
      check("pause_quiet", 128'(cnt), 128'(0));
      bus.game_state = 2'b10;
      wait_done("pause_resume", 2 * PER, k);
      check("pause_resume_latency", 128'(k), 128'(PER));
      check("pause_resume_count", 128'(bus.gen_count), 128'(2));

      // asynchronous reset mid-scan
      wait_busy("rst_busy_wait", 2 * PER);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_board", 128'(bus.board), 128'(0));
      check("arst_busy", 128'(bus.busy), 128'(0));
      check("arst_gen_done", 128'(bus.gen_done), 128'(0));
      check("arst_count", 128'(bus.gen_count), 128'(0));
      #1 rst = 1'b0;
      @(negedge clk);
      wait_done("arst_resume", 2 * PER, k);
      check("arst_resume_latency", 128'(k), 128'(PER));
      check("arst_resume_count", 128'(bus.gen_count), 128'(1));

      // 8x15 build: cursor beyond the board is ignored, last cell is editable
      bus15.game_state = 2'b01;
      press15(127, 1'b0, 1'b1);
      check("b15_oob", 128'(bus15.board), 128'(0));
      press15(119, 1'b0, 1'b1);
      check("b15_last", 128'(bus15.board), 128'(1) << 119);

      // randomized sessions, checked each cycle against the model
      for (int round = 0; round < 6; round++) begin
         bus.game_state = 2'b00;
         repeat (2) @(negedge clk);
         bus.game_state = 2'b01;
         for (int p = 0; p < 30; p++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
               0, 1, 2: press(int'($urandom_range(0, N - 1)), 1'b0, 1'b1);
               3:       press(int'($urandom_range(0, N - 1)), 1'b1, 1'b0);
               4:       press(int'($urandom_range(0, N - 1)), 1'b1, 1'b1);
               default: @(negedge clk);
            endcase
         end
         bus.game_state = 2'b10;
         for (int c = 0; c < 500; c++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 3) bus.game_state = (bus.game_state == 2'b10) ? 2'b11 : 2'b10;
            if (sel == 50) press(int'($urandom_range(0, N - 1)), 1'b0, 1'b1);
            else @(negedge clk);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
